bw_game_ctrl: RTL and testbench



---
 rtl/bw_pkg.sv | 35 +++
 rtl/bw_hand.sv | 30 +++
 rtl/bw_game_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_bw_game_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_pkg.sv
// Shared constants, state/winner encodings and tile helpers for the
// Black-and-White round sequencer.
package bw_pkg;

  localparam int TILE_W    = 4;
  localparam int NUM_TILES = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_FOLLOW,
    S_CMP,
    S_SHOW,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    WIN_TIE = 2'b00,
    WIN_P1  = 2'b01,
    WIN_P2  = 2'b10
  } win_t;

  // Even tiles are black.
  function automatic logic is_black(input logic [TILE_W-1:0] tile);
    return (tile & TILE_W'(1)) == '0;
  endfunction

  // a belongs to P1, b to P2; the larger value takes the point.
  function automatic win_t higher(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return WIN_P1;
    if (b > a) return WIN_P2;
    return WIN_TIE;
  endfunction

endpackage

// File: rtl/bw_hand.sv
// One player's hand: a mask of unplayed tiles (bit i = tile i+1) with a
// combinational legality check for the presented tile.
module bw_hand
  import bw_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reload,
  input  logic                 consume,
  input  logic [TILE_W-1:0]    tile,
  output logic [NUM_TILES-1:0] mask,
  output logic                 legal
);

  logic                 in_range;
  logic [NUM_TILES-1:0] tile_bit;

  always_comb begin
    in_range = (tile != '0) && (tile <= TILE_W'(NUM_TILES));
    tile_bit = '0;
    if (in_range) tile_bit = NUM_TILES'(1) << (tile - TILE_W'(1));
    legal = in_range && ((mask & tile_bit) != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || reload) mask <= '1;
    else if (consume)       mask <= mask & ~tile_bit;
  end

endmodule

// File: rtl/bw_game_ctrl.sv
// Round sequencer for the two-player Black-and-White tile game: takes the
// leader's and follower's picks, scores each round and detects game end.
module bw_game_ctrl
  import bw_pkg::*;
#(
  parameter int SHOW_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 p1_valid,
  input  logic [TILE_W-1:0]    p1_tile,
  input  logic                 p2_valid,
  input  logic [TILE_W-1:0]    p2_tile,
  output logic [NUM_TILES-1:0] hand1,
  output logic [NUM_TILES-1:0] hand2,
  output logic                 leader,
  output logic                 lead_color_valid,
  output logic                 lead_color,
  output logic                 pick_err,
  output logic                 round_done,
  output logic [1:0]           round_winner,
  output logic [3:0]           round_num,
  output logic [3:0]           score1,
  output logic [3:0]           score2,
  output logic                 game_over,
  output logic [1:0]           game_winner
);

  // Pick strobes: pX_valid is a one-cycle offer of pX_tile with no
  // backpressure. It is consumed only when that player is the one being
  // asked (leader in S_LEAD, follower in S_FOLLOW); otherwise it is dropped
  // silently. An offered but illegal tile yields a pick_err pulse next cycle.
  state_t state, state_nxt;

  logic [TILE_W-1:0] lead_tile, follow_tile;
  logic [3:0]        show_cnt;

  logic              hand_reload, hand_consume;
  logic              lead_load, follow_load, err_nxt;
  logic [TILE_W-1:0] hand1_tile, hand2_tile;
  logic              legal1, legal2;

  logic              ldr_valid, fol_valid, ldr_legal, fol_legal;
  logic [TILE_W-1:0] ldr_tile, fol_tile, p1_play, p2_play;
  win_t              cmp_win;

  logic signed [4:0] score_diff;
  logic [4:0]        abs_diff, rounds_left;
  logic              game_decided, show_last;

  // During S_CMP each hand is presented the tile its owner played so it can
  // be removed; otherwise it checks the owner's live pick.
  always_comb begin
    p1_play    = leader ? follow_tile : lead_tile;
    p2_play    = leader ? lead_tile   : follow_tile;
    hand1_tile = (state == S_CMP) ? p1_play : p1_tile;
    hand2_tile = (state == S_CMP) ? p2_play : p2_tile;
  end

  bw_hand u_hand1 (
    .clk     (clk),
    .reset_n (reset_n),
    .reload  (hand_reload),
    .consume (hand_consume),
    .tile    (hand1_tile),
    .mask    (hand1),
    .legal   (legal1)
  );

  bw_hand u_hand2 (
    .clk     (clk),
    .reset_n (reset_n),
    .reload  (hand_reload),
    .consume (hand_consume),
    .tile    (hand2_tile),
    .mask    (hand2),
    .legal   (legal2)
  );

  always_comb begin
    ldr_valid = leader ? p2_valid : p1_valid;
    ldr_tile  = leader ? p2_tile  : p1_tile;
    ldr_legal = leader ? legal2   : legal1;
    fol_valid = leader ? p1_valid : p2_valid;
    fol_tile  = leader ? p1_tile  : p2_tile;
    fol_legal = leader ? legal1   : legal2;
    cmp_win   = higher(p1_play, p2_play);
  end

  // Decided when the trailing player cannot catch up even by winning
  // every remaining round.
  always_comb begin
    score_diff   = $signed({1'b0, score1}) - $signed({1'b0, score2});
    abs_diff     = score_diff[4] ? $unsigned(-score_diff) : $unsigned(score_diff);
    rounds_left  = 5'(NUM_TILES) - {1'b0, round_num};
    game_decided = (round_num == 4'(NUM_TILES)) || (abs_diff > rounds_left);
    show_last    = (show_cnt == 4'(SHOW_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    hand_reload  = 1'b0;
    hand_consume = 1'b0;
    lead_load    = 1'b0;
    follow_load  = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          hand_reload = 1'b1;
          state_nxt   = S_LEAD;
        end
      end
      S_LEAD: begin
        if (ldr_valid) begin
          if (ldr_legal) begin
            lead_load = 1'b1;
            state_nxt = S_FOLLOW;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_FOLLOW: begin
        if (fol_valid) begin
          if (fol_legal) begin
            follow_load = 1'b1;
            state_nxt   = S_CMP;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_CMP: begin
        hand_consume = 1'b1;
        state_nxt    = S_SHOW;
      end
      S_SHOW: begin
        if (show_last) state_nxt = game_decided ? S_DONE : S_LEAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lead_tile    <= '0;
      follow_tile  <= '0;
      show_cnt     <= '0;
      score1       <= '0;
      score2       <= '0;
      round_num    <= '0;
      round_winner <= WIN_TIE;
      leader       <= 1'b0;
      pick_err     <= 1'b0;
      round_done   <= 1'b0;
    end else begin
      pick_err   <= err_nxt;
      round_done <= (state == S_CMP);
      show_cnt   <= (state == S_SHOW) ? show_cnt + 4'd1 : 4'd0;
      if (lead_load)   lead_tile   <= ldr_tile;
      if (follow_load) follow_tile <= fol_tile;
      if (hand_reload) begin
        score1       <= '0;
        score2       <= '0;
        round_num    <= '0;
        round_winner <= WIN_TIE;
        leader       <= 1'b0;
      end
      if (state == S_CMP) begin
        round_num    <= round_num + 4'd1;
        round_winner <= cmp_win;
        if (cmp_win == WIN_P1) begin
          score1 <= score1 + 4'd1;
          leader <= 1'b0;
        end else if (cmp_win == WIN_P2) begin
          score2 <= score2 + 4'd1;
          leader <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    lead_color_valid = (state == S_FOLLOW);
    lead_color       = lead_color_valid && is_black(lead_tile);
    game_over        = (state == S_DONE);
    game_winner      = game_over ? higher(score1, score2) : WIN_TIE;
  end

endmodule

// File: tb/tb_bw_game_ctrl.sv
// Bench for bw_game_ctrl: directed game scenarios plus random games, checked
// every cycle against a round-level model of the game rules.
module tb_bw_game_ctrl;

  localparam int SHOW = 4;

  logic       clk = 1'b0;
  logic       reset_n, start, p1_valid, p2_valid;
  logic [3:0] p1_tile, p2_tile;
  logic [8:0] hand1, hand2;
  logic       leader, lead_color_valid, lead_color, pick_err, round_done, game_over;
  logic [1:0] round_winner, game_winner;
  logic [3:0] round_num, score1, score2;

  bw_game_ctrl #(.SHOW_CYCLES(SHOW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .p1_valid         (p1_valid),
    .p1_tile          (p1_tile),
    .p2_valid         (p2_valid),
    .p2_tile          (p2_tile),
    .hand1            (hand1),
    .hand2            (hand2),
    .leader           (leader),
    .lead_color_valid (lead_color_valid),
    .lead_color       (lead_color),
    .pick_err         (pick_err),
    .round_done       (round_done),
    .round_winner     (round_winner),
    .round_num        (round_num),
    .score1           (score1),
    .score2           (score2),
    .game_over        (game_over),
    .game_winner      (game_winner)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  int  n_total = 0;
  int  n_bad   = 0;
  bit  chk_en  = 1'b0;
  bit  m_hand[2][1:9];
  int  m_score[2];
  int  m_rounds, m_leader, m_winner, m_lead_t, m_fol_t;
  bit  exp_lcv, exp_lc, exp_pick_err, exp_round_done, exp_game_over;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mask_of(input int who);
    logic [8:0] m;
    m = '0;
    for (int t = 1; t <= 9; t++) m[t-1] = m_hand[who][t];
    return m;
  endfunction

  function automatic int game_result();
    if (m_score[0] > m_score[1]) return 1;
    if (m_score[1] > m_score[0]) return 2;
    return 0;
  endfunction

  function automatic bit model_legal(input int who, input int t);
    if (t < 1 || t > 9) return 1'b0;
    return m_hand[who][t];
  endfunction

  function automatic int rand_legal(input int who);
    int q[$];
    for (int t = 1; t <= 9; t++) if (m_hand[who][t]) q.push_back(t);
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic model_new_game();
    for (int p = 0; p < 2; p++)
      for (int t = 1; t <= 9; t++) m_hand[p][t] = 1'b1;
    m_score[0] = 0;
    m_score[1] = 0;
    m_rounds = 0;
    m_winner = 0;
    m_leader = 0;
    exp_game_over = 1'b0;
    exp_lcv = 1'b0;
    exp_lc = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("hand1",            32'(hand1),            32'(mask_of(0)));
      check("hand2",            32'(hand2),            32'(mask_of(1)));
      check("leader",           32'(leader),           32'(m_leader));
      check("lead_color_valid", 32'(lead_color_valid), 32'(exp_lcv));
      check("lead_color",       32'(lead_color),       32'(exp_lc));
      check("pick_err",         32'(pick_err),         32'(exp_pick_err));
      check("round_done",       32'(round_done),       32'(exp_round_done));
      check("round_winner",     32'(round_winner),     32'(m_winner));
      check("round_num",        32'(round_num),        32'(m_rounds));
      check("score1",           32'(score1),           32'(m_score[0]));
      check("score2",           32'(score2),           32'(m_score[1]));
      check("game_over",        32'(game_over),        32'(exp_game_over));
      if (exp_game_over) check("game_winner", 32'(game_winner), 32'(game_result()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    exp_pick_err   = 1'b0;
    exp_round_done = 1'b0;
  endtask

  task automatic clear_inputs();
    start = 1'b0;
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    p1_tile = '0;
    p2_tile = '0;
  endtask

  task automatic drive(input int who, input int t);
    if (who == 0) begin
      p1_valid = 1'b1;
      p1_tile  = 4'(t);
    end else begin
      p2_valid = 1'b1;
      p2_tile  = 4'(t);
    end
  endtask

  task automatic new_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
    model_new_game();
  endtask

  // One-cycle pick offer; during the lead phase the other player may strobe
  // at the same time and must be ignored.
  task automatic try_pick(input int who, input int t, input bit fol_phase, output bit ok);
    ok = model_legal(who, t);
    drive(who, t);
    if (!fol_phase && $urandom_range(0, 1) == 1) drive(1 - who, $urandom_range(0, 15));
    cyc();
    clear_inputs();
    exp_pick_err = !ok;
    if (ok && !fol_phase) begin
      m_lead_t = t;
      exp_lcv  = 1'b1;
      exp_lc   = (t % 2 == 0);
    end else if (ok) begin
      m_fol_t = t;
      exp_lcv = 1'b0;
      exp_lc  = 1'b0;
    end
  endtask

  // Compare cycle, then the show window with start and junk strobes held.
  task automatic finish_round();
    int p1t, p2t, diff;
    bit decided;
    cyc();
    p1t = (m_leader == 0) ? m_lead_t : m_fol_t;
    p2t = (m_leader == 0) ? m_fol_t : m_lead_t;
    m_hand[0][p1t] = 1'b0;
    m_hand[1][p2t] = 1'b0;
    if (p1t > p2t) begin
      m_score[0]++;
      m_winner = 1;
      m_leader = 0;
    end else if (p2t > p1t) begin
      m_score[1]++;
      m_winner = 2;
      m_leader = 1;
    end else begin
      m_winner = 0;
    end
    m_rounds++;
    exp_round_done = 1'b1;
    diff = m_score[0] - m_score[1];
    if (diff < 0) diff = -diff;
    decided = (m_rounds == 9) || (diff > 9 - m_rounds);
    for (int i = 0; i < SHOW; i++) begin
      start    = 1'b1;
      p1_valid = 1'($urandom_range(0, 1));
      p1_tile  = 4'($urandom_range(0, 15));
      p2_valid = 1'($urandom_range(0, 1));
      p2_tile  = 4'($urandom_range(0, 15));
      cyc();
    end
    clear_inputs();
    if (decided) exp_game_over = 1'b1;
  endtask

  task automatic play_round(input int lt, input int ft);
    bit ok;
    try_pick(m_leader, lt, 1'b0, ok);
    try_pick(1 - m_leader, ft, 1'b1, ok);
    finish_round();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int ldr;
    reset_n = 1'b0;
    clear_inputs();
    model_new_game();
    repeat (2) cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_hand1", 32'(hand1), 32'h1FF);
    check("rst_hand2", 32'(hand2), 32'h1FF);
    check("rst_game_over", 32'(game_over), 32'h0);
    reset_n = 1'b1;
    cyc();
    new_game();

    // round 1: P1 leads 8 (black), P2 answers 5
    try_pick(0, 8, 1'b0, ok);
    check("t1_lcv", 32'(lead_color_valid), 32'h1);
    check("t1_lead_color", 32'(lead_color), 32'h1);
    try_pick(1, 5, 1'b1, ok);
    finish_round();
    check("t1_hand1", 32'(hand1), 32'h17F);
    check("t1_hand2", 32'(hand2), 32'h1EF);
    check("t1_score1", 32'(score1), 32'h1);
    check("t1_winner", 32'(round_winner), 32'h1);
    check("t1_leader", 32'(leader), 32'h0);

    // illegal leader picks, then a lone follower strobe in the lead phase
    try_pick(0, 0, 1'b0, ok);
    check("t2_err_tile0", 32'(pick_err), 32'h1);
    try_pick(0, 10, 1'b0, ok);
    check("t2_err_tile10", 32'(pick_err), 32'h1);
    try_pick(0, 8, 1'b0, ok);
    check("t2_err_reuse8", 32'(pick_err), 32'h1);
    check("t2_still_lead", 32'(lead_color_valid), 32'h0);
    p2_valid = 1'b1;
    p2_tile  = 4'd4;
    cyc();
    clear_inputs();
    check("t2_p2_ignored_err", 32'(pick_err), 32'h0);
    check("t2_p2_ignored_lcv", 32'(lead_color_valid), 32'h0);

    // tie round on tile 3
    play_round(3, 3);
    check("t3_winner", 32'(round_winner), 32'h0);
    check("t3_score1", 32'(score1), 32'h1);
    check("t3_score2", 32'(score2), 32'h0);
    check("t3_hand1", 32'(hand1), 32'h17B);
    check("t3_hand2", 32'(hand2), 32'h1EB);
    check("t3_leader", 32'(leader), 32'h0);

    // reset while waiting for the follower, with an illegal pick in flight
    try_pick(0, 9, 1'b0, ok);
    reset_n = 1'b0;
    drive(1, 15);
    cyc();
    clear_inputs();
    model_new_game();
    check("t6_hand1", 32'(hand1), 32'h1FF);
    check("t6_score1", 32'(score1), 32'h0);
    check("t6_round_num", 32'(round_num), 32'h0);
    check("t6_pick_err", 32'(pick_err), 32'h0);
    check("t6_lcv", 32'(lead_color_valid), 32'h0);
    reset_n = 1'b1;
    cyc();

    // P1 wins five straight: decided at 5-0 with four rounds left
    new_game();
    play_round(8, 1);
    play_round(7, 2);
    play_round(6, 3);
    play_round(5, 4);
    check("t4_not_over_r4", 32'(game_over), 32'h0);
    play_round(9, 5);
    check("t4_over", 32'(game_over), 32'h1);
    check("t4_game_winner", 32'(game_winner), 32'h1);
    check("t4_round_num", 32'(round_num), 32'h5);
    check("t4_score1", 32'(score1), 32'h5);

    // nine ties from DONE: draw with both hands empty
    new_game();
    for (int t = 9; t >= 1; t--) play_round(t, t);
    check("t5_over", 32'(game_over), 32'h1);
    check("t5_game_winner", 32'(game_winner), 32'h0);
    check("t5_round_num", 32'(round_num), 32'h9);
    check("t5_hand1", 32'(hand1), 32'h0);
    check("t5_hand2", 32'(hand2), 32'h0);

    // random games with occasional illegal attempts
    repeat (8) begin
      new_game();
      while (!exp_game_over) begin
        ldr = m_leader;
        ok = 1'b0;
        if ($urandom_range(0, 2) == 0) try_pick(ldr, $urandom_range(0, 15), 1'b0, ok);
        if (!ok) try_pick(ldr, rand_legal(ldr), 1'b0, ok);
        ok = 1'b0;
        if ($urandom_range(0, 2) == 0) try_pick(1 - ldr, $urandom_range(0, 15), 1'b1, ok);
        if (!ok) try_pick(1 - ldr, rand_legal(1 - ldr), 1'b1, ok);
        finish_round();
      end
      repeat (2) cyc();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
